tag_ready_table: RTL

- Binary-tag-to-one-hot decode side of the physical-register tag path: decodes allocate and writeback tags into per-entry set/clear strobes.
- Holds the registered ready bit for every physical register tag.
- Sits between rename (allocate port marks a destination busy) and the CDB (writeback port marks it ready).
- Rename and the issue queues read source-operand readiness through two read ports.

---
 rtl/tag_ready_table_pkg.sv | 11 +
 rtl/tag_ready_table_tag_decoder.sv | 16 +
 rtl/tag_ready_table.sv | 86 ++++++++
 3 files changed

// File: rtl/tag_ready_table_pkg.sv
// Shared physical-register tag definitions for the rename/CDB tag path.
package tag_ready_table_pkg;

  localparam int unsigned NUM_PREGS  = 64;
  localparam int unsigned PREG_TAG_W = $clog2(NUM_PREGS);

  typedef logic [PREG_TAG_W-1:0] preg_tag_t;

  localparam preg_tag_t PREG_ZERO = '0;

endpackage : tag_ready_table_pkg

// File: rtl/tag_ready_table_tag_decoder.sv
// Binary-to-one-hot tag decoder with enable; inverse of the one-hot encoder.
module tag_decoder #(
  parameter int unsigned N = 64,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         en_i,
  input  logic [W-1:0] tag_i,
  output logic [N-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[tag_i] = 1'b1;
  end

endmodule : tag_decoder

// File: rtl/tag_ready_table.sv
// Registered per-tag ready bits: rename allocates (busy), CDB writeback readies.
// Define READY_BYPASS_EN to make a same-cycle writeback visible on the read ports.
module tag_ready_table
  import tag_ready_table_pkg::*;
#(
  parameter int unsigned NUM_TAGS = NUM_PREGS,
  localparam int unsigned TAG_W   = $clog2(NUM_TAGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alloc_valid,
  input  logic [TAG_W-1:0]    alloc_tag,
  input  logic                wb_valid,
  input  logic [TAG_W-1:0]    wb_tag,
  input  logic                flush,
  input  logic [TAG_W-1:0]    rd0_tag,
  input  logic [TAG_W-1:0]    rd1_tag,
  output logic                rd0_ready,
  output logic                rd1_ready,
  output logic [NUM_TAGS-1:0] ready_vec,
  output logic [TAG_W:0]      busy_count
);

  logic [NUM_TAGS-1:0] ready_q, ready_d;
  logic [TAG_W:0]      busy_q, busy_d;
  logic [NUM_TAGS-1:0] alloc_oh, wb_oh;
  logic                alloc_en;
  logic                go_busy, go_ready;

  // Tag 0 is architectural x0 and can never be marked busy.
  assign alloc_en = alloc_valid && (alloc_tag != TAG_W'(PREG_ZERO));

  tag_decoder #(.N(NUM_TAGS), .W(TAG_W)) u_alloc_dec (
    .en_i     (alloc_en),
    .tag_i    (alloc_tag),
    .onehot_o (alloc_oh)
  );

  tag_decoder #(.N(NUM_TAGS), .W(TAG_W)) u_wb_dec (
    .en_i     (wb_valid),
    .tag_i    (wb_tag),
    .onehot_o (wb_oh)
  );

  // Count only real transitions; alloc wins over a same-tag writeback.
  assign go_busy  = |(alloc_oh & ready_q);
  assign go_ready = |(wb_oh & ~ready_q & ~alloc_oh);

  always_comb begin
    ready_d    = (ready_q | wb_oh) & ~alloc_oh;
    ready_d[0] = 1'b1;
    busy_d     = busy_q;
    if (flush) begin
      ready_d = '1;
      busy_d  = '0;
    end else if (go_busy && !go_ready) begin
      busy_d = busy_q + 1'b1;
    end else if (go_ready && !go_busy) begin
      busy_d = busy_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= '1;
      busy_q  <= '0;
    end else begin
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign ready_vec  = ready_q;
  assign busy_count = busy_q;

`ifdef READY_BYPASS_EN
  assign rd0_ready = ready_q[rd0_tag] |
                     (wb_valid && (wb_tag == rd0_tag) && !(alloc_valid && (alloc_tag == rd0_tag)));
  assign rd1_ready = ready_q[rd1_tag] |
                     (wb_valid && (wb_tag == rd1_tag) && !(alloc_valid && (alloc_tag == rd1_tag)));
`else
  assign rd0_ready = ready_q[rd0_tag];
  assign rd1_ready = ready_q[rd1_tag];
`endif

endmodule : tag_ready_table
